ia_tx: RTL and testbench

- Readback transmitter for the input-assembly path: serializes the parameter frame held in the top-level register file (world vertices, normal, light, VP matrix, render mode) back to the host over a UART line, 8N1, LSB first.
- Frame on the wire: header byte 0xA5, then FRAME_LEN payload bytes in index order 0..FRAME_LEN-1, then an 8-bit checksum.
- Sits beside `ia`, sharing its byte indexing, so the host can confirm exactly what the GPU latched before rendering.

---
 rtl/ia_pkg.sv | 8 +
 rtl/ia_tx_uart_tx_core.sv | 47 ++++
 rtl/ia_tx.sv | 88 ++++++++
 tb/tb_ia_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ia_pkg.sv
// ia_pkg: frame FSM states, header and byte-index constants shared by ia and ia_tx.
package ia_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
    localparam logic [7:0] IA_HEADER       = 8'hA5;
    localparam int         IA_FRAME_LEN    = 60;
    localparam logic [6:0] IDX_X_WORLD_V0  = 7'd0;
    localparam logic [6:0] IDX_RENDER_MODE = 7'd59;
endpackage

// File: rtl/ia_tx_uart_tx_core.sv
// uart_tx_core: 8N1 LSB-first byte serializer; load starts the start bit on the next edge.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       tick,
    output logic [3:0] bit_idx,
    output logic       byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    logic          act_q, act_d, tx_q, tx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    sh_q, sh_d;
    always_comb begin
        tick      = act_q && cnt_q == '0;
        byte_done = tick && bit_q == 4'd9;
        act_d     = load ? 1'b1 : byte_done ? 1'b0 : act_q;
        cnt_d     = (load || tick) ? CNT_MAX : act_q ? cnt_q - 1'b1 : cnt_q;
        bit_d     = load ? 4'd0 : tick ? bit_q + 4'd1 : bit_q;
        // stop bit rides above the data; ones shift in behind it so the line rests high
        sh_d      = load ? {1'b1, byte_in} : tick ? {1'b1, sh_q[8:1]} : sh_q;
        tx_d      = load ? 1'b0 : tick ? sh_q[0] : tx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            tx_q  <= 1'b1;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q  <= '1;
        end else begin
            act_q <= act_d;
            tx_q  <= tx_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
        end
    end
    assign tx      = tx_q;
    assign bit_idx = bit_q;
endmodule

// File: rtl/ia_tx.sv
// ia_tx: reads the parameter frame back over UART as header, FRAME_LEN payload bytes, checksum.
module ia_tx
    import ia_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FRAME_LEN    = IA_FRAME_LEN,
    parameter logic [7:0] HEADER       = IA_HEADER
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [6:0] rd_idx,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam logic [7:0] LEN  = 8'(FRAME_LEN);
    localparam logic [7:0] LAST = 8'(FRAME_LEN + 1);
    state_t     state_q, state_d;
    logic [7:0] bcnt_q, bcnt_d, csum_q, csum_d, byte_in;
    logic [6:0] rd_idx_q, rd_idx_d;
    logic       done_q, done_d, load, payload, tick, byte_done;
    logic [3:0] bit_idx;

    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk, .rst_n, .load, .byte_in, .tx, .tick, .bit_idx, .byte_done
    );

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        csum_d   = csum_q;
        rd_idx_d = rd_idx_q;
        done_d   = 1'b0;
        load     = 1'b0;
        payload  = bcnt_q != 8'd0 && bcnt_q <= LEN;
        byte_in  = bcnt_q == 8'd0 ? HEADER : payload ? rd_data : csum_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = LOAD;
                bcnt_d   = '0;
                csum_d   = '0;
                rd_idx_d = '0;
            end
            LOAD: begin
                load    = 1'b1;
                state_d = START;
                if (payload) csum_d = csum_q + rd_data;
            end
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_idx == 4'd8) state_d = STOP;
            STOP: if (byte_done) begin
                if (bcnt_q == LAST) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    rd_idx_d = '0;
                end else begin
                    state_d = LOAD;
                    bcnt_d  = bcnt_q + 8'd1;
                    // next byte is payload bcnt_q; past the payload rd_idx parks on the last index
                    if (bcnt_q < LEN) rd_idx_d = bcnt_q[6:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bcnt_q   <= '0;
            csum_q   <= '0;
            rd_idx_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            csum_q   <= csum_d;
            rd_idx_q <= rd_idx_d;
            done_q   <= done_d;
        end
    end

    assign rd_idx = rd_idx_q;
    assign busy   = state_q != IDLE;
    assign done   = done_q;
endmodule

// File: tb/tb_ia_tx.sv
// tb_ia_tx: directed/random frames on a 3-byte and a 60-byte ia_tx, checked against a wire-level model.
module tb_ia_tx;
    localparam int BT = 41;
    logic       clk = 0, rst_n = 1, start0 = 0, start1 = 0;
    logic [6:0] rd_idx0, rd_idx1;
    logic [7:0] rd_data0, rd_data1;
    logic       tx0, tx1, busy0, busy1, done0, done1;
    logic [7:0] mem0 [0:127];
    logic [7:0] mem1 [0:127];
    int         cyc = 0, checks = 0, failures = 0, dc0 = 0, dc1 = 0;
    bit   [7:0] exp_q [$];

    assign rd_data0 = mem0[rd_idx0];
    assign rd_data1 = mem1[rd_idx1];

    ia_tx #(.CLKS_PER_BIT(4), .FRAME_LEN(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .rd_idx(rd_idx0), .rd_data(rd_data0),
        .tx(tx0), .busy(busy0), .done(done0)
    );
    ia_tx #(.CLKS_PER_BIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rd_idx(rd_idx1), .rd_data(rd_data1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done0 === 1'b1) dc0 <= dc0 + 1;
        if (done1 === 1'b1) dc1 <= dc1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build_exp(input int w);
        int n;
        int s;
        n = w ? 60 : 3;
        s = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(w ? mem1[i] : mem0[i]);
            s += int'(w ? mem1[i] : mem0[i]);
        end
        exp_q.push_back(s[7:0]);
    endfunction

    task automatic pulse_start(input int w, output int t0);
        @(negedge clk);
        if (w != 0) start1 = 1; else start0 = 1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start0 = 0;
        start1 = 0;
    endtask

    // Walks the frame cycle by cycle from its first LOAD cycle t0; every byte is one idle-high
    // cycle followed by start, 8 data bits LSB first and stop, each 4 clocks long.
    task automatic run_frame(input int w, input int t0, input bit chain);
        int n;
        int len;
        int dc_before;
        n = exp_q.size();
        len = w ? 60 : 3;
        dc_before = w ? dc1 : dc0;
        while (cyc < t0) @(negedge clk);
        for (int j = 0; j < n; j++) begin
            logic [7:0] obs;
            int bad;
            obs = 'x;
            bad = 0;
            for (int o = 0; o < BT; o++) begin
                int b;
                logic e, t;
                b = (o == 0) ? -1 : (o - 1) / 4;
                e = (o == 0) ? 1'b1 : (b == 0) ? 1'b0 : (b <= 8) ? exp_q[j][b-1] : 1'b1;
                t = w ? tx1 : tx0;
                if (t !== e) bad++;
                if ((w ? busy1 : busy0) !== 1'b1) bad++;
                if (b >= 1 && b <= 8 && (o - 1) % 4 == 2) obs[b-1] = t;
                if (o == 0)
                    check($sformatf("idx%0d_%0d", w, j), 32'(w ? rd_idx1 : rd_idx0),
                          j == 0 ? 0 : (j <= len ? j - 1 : len - 1));
                @(negedge clk);
            end
            check($sformatf("byte%0d_%0d", w, j), 32'(obs), 32'(exp_q[j]));
            check($sformatf("wave%0d_%0d", w, j), bad, 0);
        end
        check("done_hi", 32'(w ? done1 : done0), 1);
        check("busy_end", 32'(w ? busy1 : busy0), 0);
        if (chain) begin
            if (w != 0) start1 = 1; else start0 = 1;
        end
        @(negedge clk);
        start0 = 0;
        start1 = 0;
        check("done_lo", 32'(w ? done1 : done0), 0);
        check("done_cnt", w ? dc1 : dc0, dc_before + 1);
    endtask

    initial begin
        int t0, t1, d;
        logic [7:0] o0, n0, n1;
        for (int i = 0; i < 128; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        #2 rst_n = 0;
        #10;
        check("rst_tx0", 32'(tx0), 1);
        check("rst_busy0", 32'(busy0), 0);
        check("rst_done0", 32'(done0), 0);
        check("rst_idx0", 32'(rd_idx0), 0);
        check("rst_tx1", 32'(tx1), 1);
        check("rst_busy1", 32'(busy1), 0);
        @(negedge clk);
        rst_n = 1;

        // basic frame: A5 01 02 03 06
        mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h03;
        build_exp(0);
        pulse_start(0, t0);
        check("busy_load", 32'(busy0), 1);
        run_frame(0, t0, 0);

        // checksum wraps modulo 256
        mem0[0] = 8'hFF; mem0[1] = 8'hFF; mem0[2] = 8'h03;
        build_exp(0);
        pulse_start(0, t0);
        run_frame(0, t0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) mem0[i] = 8'($urandom);
            build_exp(0);
            if (r == 2) begin
                o0 = mem0[0];
                n0 = o0 ^ 8'h5A;
                n1 = 8'($urandom);
                exp_q = {8'hA5, o0, n1, mem0[2], 8'(o0 + n1 + mem0[2])};
            end
            pulse_start(0, t0);
            fork
                run_frame(0, t0, 0);
                begin
                    repeat (r == 1 ? 60 : 50) @(negedge clk);
                    if (r == 1) begin
                        start0 = 1;
                        @(negedge clk);
                        start0 = 0;
                    end
                    if (r == 2) begin
                        mem0[0] = n0;
                        mem0[1] = n1;
                    end
                end
            join
            repeat (20) @(negedge clk);
            check($sformatf("idle_after%0d", r), 32'(busy0), 0);
        end

        // start in the done cycle chains straight into the next frame
        for (int i = 0; i < 3; i++) mem0[i] = 8'($urandom);
        build_exp(0);
        pulse_start(0, t0);
        run_frame(0, t0, 1);
        t1 = t0 + 5 * BT + 1;
        check("chain_busy", 32'(busy0), 1);
        for (int i = 0; i < 3; i++) mem0[i] = 8'($urandom);
        build_exp(0);
        run_frame(0, t1, 0);

        // reset during data bit 3 of the first payload byte
        mem0[0] = 8'h00; mem0[1] = 8'($urandom); mem0[2] = 8'($urandom);
        pulse_start(0, t0);
        repeat (59) @(negedge clk);
        check("pre_rst_tx", 32'(tx0), 0);
        d = dc0;
        rst_n = 0;
        #1;
        check("mid_rst_tx", 32'(tx0), 1);
        check("mid_rst_busy", 32'(busy0), 0);
        check("mid_rst_done", 32'(done0), 0);
        repeat (3) @(negedge clk);
        check("mid_rst_nodone", dc0, d);
        rst_n = 1;
        build_exp(0);
        pulse_start(0, t0);
        run_frame(0, t0, 0);

        // full 60-byte register file; render_mode is the 61st byte on the wire
        for (int i = 0; i < 59; i++) mem1[i] = 8'($urandom);
        mem1[59] = 8'($urandom_range(0, 3));
        build_exp(1);
        pulse_start(1, t0);
        run_frame(1, t0, 0);
        check("idx1_idle", 32'(rd_idx1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
